// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-timing helpers.
// The transmitter uses clks_per_bit() so both sides agree on the bit period.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

  // Clocks per serial bit (T), integer division.
  function automatic int unsigned clks_per_bit(input int unsigned freq,
                                               input int unsigned baud);
    return freq / baud;
  endfunction

  // Half a bit period (H), truncated; used to find the middle of the start bit.
  function automatic int unsigned half_bit(input int unsigned freq,
                                           input int unsigned baud);
    return clks_per_bit(freq, baud) / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; both come out of reset at RESET_VAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Detects the start edge, confirms it mid-bit, then samples
// each data bit and the stop bit one full bit period apart.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUDRATE = 115200,
  parameter int unsigned FREQ     = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned T  = clks_per_bit(FREQ, BAUDRATE);
  localparam int unsigned H  = half_bit(FREQ, BAUDRATE);
  localparam int unsigned CW = (T > 1) ? $clog2(T) : 1;
  localparam logic [CW-1:0] TLast = CW'(T - 1);
  localparam logic [CW-1:0] HLast = CW'(H - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_clk_q, cnt_clk_d;
  logic [2:0]    cnt_bit_q, cnt_bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          frame_err_q, frame_err_d;
  logic          rx_s, rx_d, fall;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  // Delay flop for edge detection on the synchronized line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_d <= 1'b1;
    else     rx_d <= rx_s;
  end

  assign fall = rx_d & ~rx_s;

  // Next-state, counters, shift register and output pulses.
  always_comb begin
    state_d     = state_q;
    cnt_clk_d   = cnt_clk_q;
    cnt_bit_d   = cnt_bit_q;
    shreg_d     = shreg_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fall) begin
          state_d   = StStart;
          cnt_clk_d = '0;
        end
      end
      StStart: begin
        if (cnt_clk_q == HLast) begin
          cnt_clk_d = '0;
          cnt_bit_d = '0;
          // Line back high at mid start bit: treat as a glitch.
          state_d   = rx_s ? StIdle : StData;
        end else begin
          cnt_clk_d = cnt_clk_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_clk_q == TLast) begin
          cnt_clk_d          = '0;
          shreg_d[cnt_bit_q] = rx_s;
          if (cnt_bit_q == 3'd7) begin
            state_d   = StStop;
            cnt_bit_d = '0;
          end else begin
            cnt_bit_d = cnt_bit_q + 3'd1;
          end
        end else begin
          cnt_clk_d = cnt_clk_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_clk_q == TLast) begin
          cnt_clk_d = '0;
          if (rx_s) begin
            rdata_d  = shreg_q;
            rvalid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          // An edge arriving right as the frame closes starts the next frame.
          state_d = fall ? StStart : StIdle;
        end else begin
          cnt_clk_d = cnt_clk_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_clk_q   <= '0;
      cnt_bit_q   <= '0;
      shreg_q     <= '0;
      rdata_q     <= 8'h00;
      rvalid_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_clk_q   <= cnt_clk_d;
      cnt_bit_q   <= cnt_bit_d;
      shreg_q     <= shreg_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 10 clk per bit. Frames are driven on rx; the
// expected outcome (byte or frame error) is queued when the frame is issued and
// a monitor pops and compares on every rvalid / frame_err pulse.
module tb_uart_rx;

  localparam int unsigned Freq = 50_000_000;
  localparam int unsigned Baud = 5_000_000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rdata;
  logic       rvalid, frame_err, busy;

  always #5 clk = ~clk;

  uart_rx #(
    .BAUDRATE(Baud),
    .FREQ    (Freq)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] model_rdata = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (rvalid || frame_err)) begin
      check("pulse_exclusive", 32'(rvalid & frame_err), 32'd0);
      check("expected_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("pulse_kind_ferr", 32'(frame_err), 32'(mon_e.is_err));
        check("pulse_rdata", 32'(rdata), 32'(mon_e.data));
      end
    end
  end

  // Drive rx to v for n clocks; always entered and left 1 time unit after posedge.
  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mode 0: 10 clk every bit; 1: alternating 9/11; 2: alternating 11/9.
  function automatic int bit_period(input int mode, input int j);
    if (mode == 1) return (j % 2 == 0) ? 9 : 11;
    if (mode == 2) return (j % 2 == 0) ? 11 : 9;
    return 10;
  endfunction

  // Reference model: a good stop bit delivers the byte; a bad one reports an
  // error and leaves the last good byte on rdata.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int mode);
    logic [9:0] bits;
    exp_t       e;
    bits = {stop, b, 1'b0};
    if (stop) begin
      e.is_err    = 1'b0;
      e.data      = b;
      model_rdata = b;
    end else begin
      e.is_err = 1'b1;
      e.data   = model_rdata;
    end
    exp_q.push_back(e);
    for (int j = 0; j < 10; j++) hold(bits[j], bit_period(mode, j));
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [9:0] abort_bits;
    logic [7:0] rb;
    logic       rstop;
    int         rmode, rgap;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", 32'(rdata), 32'h00);
    check("reset_rvalid", 32'(rvalid), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    hold(1'b1, 5);

    // Single frame.
    send_frame(8'h55, 1'b1, 0);
    hold(1'b1, 10);
    wait_drain(50);
    check("idle_busy_55", 32'(busy), 32'd0);

    // Back-to-back frames, no idle bit.
    send_frame(8'hA3, 1'b1, 0);
    send_frame(8'h0F, 1'b1, 0);
    hold(1'b1, 10);
    wait_drain(50);
    check("rdata_hold_0f", 32'(rdata), 32'(model_rdata));

    // Short low glitch on an idle line is rejected.
    hold(1'b0, 3);
    hold(1'b1, 20);
    check("glitch_busy", 32'(busy), 32'd0);
    check("glitch_rdata", 32'(rdata), 32'(model_rdata));

    // Bad stop bit, line then held low: error once, no restart while low.
    send_frame(8'hC4, 1'b0, 0);
    hold(1'b0, 30);
    wait_drain(20);
    check("ferr_busy", 32'(busy), 32'd0);
    check("ferr_rdata_kept", 32'(rdata), 32'h0F);
    hold(1'b0, 30);
    check("ferr_no_restart", 32'(busy), 32'd0);
    hold(1'b1, 15);
    check("ferr_line_high_busy", 32'(busy), 32'd0);

    // Reset in the middle of data bit 4 of 0x96.
    abort_bits = {1'b1, 8'h96, 1'b0};
    for (int j = 0; j < 5; j++) hold(abort_bits[j], 10);
    hold(abort_bits[5], 5);
    rst = 1'b1;
    #1;
    check("abort_busy_in_reset", 32'(busy), 32'd0);
    hold(1'b1, 3);
    rst = 1'b0;
    model_rdata = 8'h00;
    check("abort_rdata_cleared", 32'(rdata), 32'h00);
    hold(1'b1, 10);
    send_frame(8'h3C, 1'b1, 0);
    hold(1'b1, 10);
    wait_drain(50);

    // Bit periods of 9 and 11 clk.
    send_frame(8'h81, 1'b1, 1);
    hold(1'b1, 10);
    wait_drain(50);
    send_frame(8'h81, 1'b1, 2);
    hold(1'b1, 10);
    wait_drain(50);

    // Random frames: random bytes, occasional bad stop, jitter and gaps.
    for (int i = 0; i < 24; i++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 7) != 0);
      rmode = int'($urandom_range(0, 2));
      rgap  = int'($urandom_range(0, 25));
      if (!rstop && rgap < 3) rgap = 3;
      send_frame(rb, rstop, rmode);
      if (rgap > 0) hold(1'b1, rgap);
    end
    hold(1'b1, 20);
    wait_drain(200);
    check("final_busy", 32'(busy), 32'd0);
    check("final_rdata", 32'(rdata), 32'(model_rdata));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter BAUDRATE, default 115200, serial bit rate in bit/s.
REQ-002 The block SHALL have parameter FREQ, default 50_000_000, clk frequency in Hz.
REQ-003 The block SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port rx  input  1  serial line, asynchronous to clk, idle high.
REQ-006 The block SHALL have port rdata  output  8  last correctly received byte.
REQ-007 The block SHALL have port rvalid  output  1  one-cycle pulse, rdata updated this cycle.
REQ-008 The block SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 The block SHALL have port busy  output  1  high while a frame is being received.

Function
REQ-010 The block SHALL use frame format 8N1: start bit 0, 8 data bits LSB first, one stop bit 1, no parity.
REQ-011 The block SHALL use T = FREQ/BAUDRATE clocks per bit (integer division) and H = T/2 (truncated).
REQ-012 The block SHALL pass rx through a 2-flop synchronizer (rx_s) plus one delay flop (rx_d); a falling edge is rx_d=1 and rx_s=0.
REQ-013 The block SHALL implement states IDLE, START, DATA, STOP with a clock counter cnt_clk and a bit counter cnt_bit (0..7).
REQ-014 In IDLE, on a falling edge, the block SHALL go to START with cnt_clk=0; otherwise it SHALL stay in IDLE.
REQ-015 In START, at cnt_clk=H-1, the block SHALL go to DATA if rx_s=0, or back to IDLE if rx_s=1 (glitch rejection), clearing cnt_clk either way.
REQ-016 In DATA, at cnt_clk=T-1, the block SHALL sample rx_s into shift-register bit position cnt_bit.
REQ-017 In DATA, at cnt_clk=T-1, the block SHALL clear cnt_clk, and after bit 7 go to STOP.
REQ-018 In STOP, at cnt_clk=T-1 with rx_s=1, the block SHALL load rdata from the shift register and pulse rvalid in the next cycle.
REQ-019 In STOP, at cnt_clk=T-1 with rx_s=0, the block SHALL pulse frame_err in the next cycle, leave rdata unchanged, and not pulse rvalid.
REQ-020 After REQ-018 or REQ-019, the block SHALL return to IDLE; a line held low after a frame error SHALL NOT start a new frame until a new falling edge occurs.
REQ-021 rdata SHALL hold its value until the next valid frame; the block has no flow control, and a new frame overwrites rdata without indication.
REQ-022 busy SHALL be high in START, DATA and STOP, and low in IDLE.
REQ-023 rvalid and frame_err SHALL never be high in the same cycle.
REQ-024 A falling edge seen in the cycle the block returns to IDLE SHALL be accepted, so back-to-back frames are received with no idle bit between them.
REQ-025 Latency SHALL be about 9.5 bit times plus 3 clk from the rx falling edge to rvalid.

Reset
REQ-026 rst high SHALL asynchronously force state=IDLE, cnt_clk=0, cnt_bit=0, the shift register to 0, rdata=8'h00, rvalid=0, frame_err=0 and busy=0.
REQ-027 rst high SHALL asynchronously force the synchronizer flops and rx_d to 1.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no rvalid or frame_err pulse, and reception SHALL resume on the first falling edge after release.

Structure
REQ-029 The state encoding and the derived constants T and H SHALL live in shared package uart_pkg, which the transmitter also uses for T.
REQ-030 The synchronizer SHALL be a separate sub-module sync_2ff (1-bit, reset value parameterized, here 1).
REQ-031 cnt_clk SHALL be $clog2(T) bits wide.

Verification (FREQ=50_000_000, BAUDRATE=5_000_000, T=10)
REQ-032 Drive frame 0x55, 10 clk/bit -> exactly one rvalid pulse with rdata=8'h55 and frame_err never high.
REQ-033 Drive 0xA3 then 0x0F back-to-back with no idle gap -> two rvalid pulses, rdata=8'hA3 then 8'h0F.
REQ-034 Drive a 3-clk low glitch on idle rx -> no busy after START timeout, no rvalid, no frame_err.
REQ-035 Drive frame 0xC4 with stop bit 0, then hold rx low for 30 clk -> one frame_err pulse, rdata unchanged, busy low, no restart until rx rises and falls again.
REQ-036 Assert rst during data bit 4 of 0x96, release, then send 0x3C -> no pulse for the aborted frame, then rvalid with rdata=8'h3C.
REQ-037 Send 0x81 with bit periods of 9 and 11 clk (±10%) -> rdata=8'h81 both times.
